// File: rtl/control_fsm_mc_pkg.sv
// Shared types and encodings for the multicycle main control unit.
//   state_t        : controller state encoding
//   OP_*           : recognised opcodes (instruction[31:26])
//   ALU_*          : ALUOp encodings
//   PCSRC_*/SRCA_*/SRCB_* : datapath mux select encodings
//   is_mem_state() : states whose length is stretched by the memory wait counter
package control_fsm_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_WB_R     = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_I     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WB   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [2:0] ALU_NOP   = 3'd0;
    localparam logic [2:0] ALU_ADD   = 3'd1;
    localparam logic [2:0] ALU_SUB   = 3'd2;
    localparam logic [2:0] ALU_FUNCT = 3'd7;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    localparam logic       SRCA_PC   = 1'b0;
    localparam logic       SRCA_REGA = 1'b1;

    localparam logic [1:0] SRCB_REGB   = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    // True for states that access memory and therefore last MEM_WAIT+1 cycles.
    function automatic logic is_mem_state(input state_t s);
        logic r;
        case (s)
            S_FETCH, S_MEM_RD, S_MEM_WR: r = 1'b1;
            default:                     r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/control_fsm_mc_mem_wait_counter.sv
// Memory wait-state counter.
//   clk, reset : clock, synchronous active-high reset
//   clear      : force count to zero (used whenever the controller is not
//                dwelling in a memory state)
//   enable     : advance count by one
//   done       : count has reached MEM_WAIT (last cycle of the access)
module control_fsm_mc_mem_wait_counter #(
    parameter int CNT_W    = 2,
    parameter int MEM_WAIT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic done
);

    logic [CNT_W-1:0] cnt_r;

    // Wait counter: clear has priority over enable.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (enable) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign done = (cnt_r == CNT_W'(MEM_WAIT));

endmodule

// File: rtl/control_fsm_mc.sv
// Multicycle main control unit (Moore FSM).
// Sequences fetch / decode / execute / memory / write-back and drives every
// datapath enable and mux select from the current state. Memory states are
// stretched by MEM_WAIT extra cycles; an unknown opcode parks the FSM in TRAP
// with the sticky excp flag set until reset.
//   clk, reset   : clock, synchronous active-high reset
//   opcode, zero : instruction[31:26] from IR, ALU zero flag
//   pcWrite, pcWriteCond, pcSource : PC load controls
//   ALUOp, aluSrcA, aluSrcB, aluOutWrite : ALU controls
//   memRd, wrMem, Load_ir : memory strobes and IR load
//   regAWrite, regBWrite, regWrite, regDst, memtoReg : register controls
//   excp         : sticky illegal-opcode flag
module control_fsm_mc
    import control_fsm_mc_pkg::*;
#(
    parameter int MEM_WAIT = 2,
    parameter int ALUOP_W  = 3,
    parameter int CNT_W    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               zero,
    output logic               pcWrite,
    output logic               pcWriteCond,
    output logic [1:0]         pcSource,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               aluSrcA,
    output logic [1:0]         aluSrcB,
    output logic               aluOutWrite,
    output logic               memRd,
    output logic               wrMem,
    output logic               Load_ir,
    output logic               regAWrite,
    output logic               regBWrite,
    output logic               regWrite,
    output logic               regDst,
    output logic               memtoReg,
    output logic               excp
);

    localparam int CNT_MAX = (32'sd1 <<< CNT_W) - 32'sd1;

    if ((MEM_WAIT < 0) || (MEM_WAIT > CNT_MAX)) begin : g_param_check
        $error("control_fsm_mc: MEM_WAIT does not fit in CNT_W bits");
    end

    state_t state_r;
    state_t next_state_s;
    logic   excp_r;
    logic   wait_done_s;
    logic   cnt_en_s;
    logic   cnt_clr_s;
    logic   unused_s;

    // The branch decision (pcWrite | pcWriteCond & zero) is formed in the
    // datapath; the controller only sees zero and does not act on it.
    assign unused_s = zero;

    // Count only while dwelling in a memory state; cleared everywhere else so
    // every memory state starts at zero.
    assign cnt_en_s  = is_mem_state(state_r) && !wait_done_s;
    assign cnt_clr_s = !cnt_en_s;

    control_fsm_mc_mem_wait_counter #(
        .CNT_W    (CNT_W),
        .MEM_WAIT (MEM_WAIT)
    ) u_wait_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clr_s),
        .enable (cnt_en_s),
        .done   (wait_done_s)
    );

    // State and sticky exception register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_FETCH;
            excp_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            excp_r  <= excp_r | (next_state_s == S_TRAP);
        end
    end

    assign excp = excp_r;

    // Next-state and Moore output decode; all strobes forced low in reset.
    always_comb begin
        next_state_s = state_r;
        pcWrite      = 1'b0;
        pcWriteCond  = 1'b0;
        pcSource     = PCSRC_ALU;
        ALUOp        = ALUOP_W'(ALU_NOP);
        aluSrcA      = SRCA_PC;
        aluSrcB      = SRCB_REGB;
        aluOutWrite  = 1'b0;
        memRd        = 1'b0;
        wrMem        = 1'b0;
        Load_ir      = 1'b0;
        regAWrite    = 1'b0;
        regBWrite    = 1'b0;
        regWrite     = 1'b0;
        regDst       = 1'b0;
        memtoReg     = 1'b0;
        if (reset) begin
            next_state_s = S_FETCH;
        end else begin
            case (state_r)
                S_FETCH: begin
                    memRd = 1'b1;
                    // IR load and PC+4 happen only on the last wait cycle.
                    if (wait_done_s) begin
                        Load_ir      = 1'b1;
                        pcWrite      = 1'b1;
                        aluSrcA      = SRCA_PC;
                        aluSrcB      = SRCB_FOUR;
                        ALUOp        = ALUOP_W'(ALU_ADD);
                        pcSource     = PCSRC_ALU;
                        next_state_s = S_DECODE;
                    end else begin
                        next_state_s = S_FETCH;
                    end
                end
                S_DECODE: begin
                    regAWrite   = 1'b1;
                    regBWrite   = 1'b1;
                    aluSrcA     = SRCA_PC;
                    aluSrcB     = SRCB_IMM_SH;
                    ALUOp       = ALUOP_W'(ALU_ADD);
                    aluOutWrite = 1'b1;
                    case (opcode)
                        OP_RTYPE:    next_state_s = S_EXEC_R;
                        OP_ADDI:     next_state_s = S_EXEC_I;
                        OP_LW, OP_SW: next_state_s = S_MEM_ADDR;
                        OP_BEQ:      next_state_s = S_BRANCH;
                        OP_J:        next_state_s = S_JUMP;
                        default:     next_state_s = S_TRAP;
                    endcase
                end
                S_EXEC_R: begin
                    aluSrcA      = SRCA_REGA;
                    aluSrcB      = SRCB_REGB;
                    ALUOp        = ALUOP_W'(ALU_FUNCT);
                    aluOutWrite  = 1'b1;
                    next_state_s = S_WB_R;
                end
                S_WB_R: begin
                    regWrite     = 1'b1;
                    regDst       = 1'b1;
                    next_state_s = S_FETCH;
                end
                S_EXEC_I: begin
                    aluSrcA      = SRCA_REGA;
                    aluSrcB      = SRCB_IMM;
                    ALUOp        = ALUOP_W'(ALU_ADD);
                    aluOutWrite  = 1'b1;
                    next_state_s = S_WB_I;
                end
                S_WB_I: begin
                    regWrite     = 1'b1;
                    next_state_s = S_FETCH;
                end
                S_MEM_ADDR: begin
                    aluSrcA     = SRCA_REGA;
                    aluSrcB     = SRCB_IMM;
                    ALUOp       = ALUOP_W'(ALU_ADD);
                    aluOutWrite = 1'b1;
                    case (opcode)
                        OP_LW:   next_state_s = S_MEM_RD;
                        OP_SW:   next_state_s = S_MEM_WR;
                        default: next_state_s = S_TRAP;
                    endcase
                end
                S_MEM_RD: begin
                    memRd = 1'b1;
                    if (wait_done_s) begin
                        next_state_s = S_MEM_WB;
                    end else begin
                        next_state_s = S_MEM_RD;
                    end
                end
                S_MEM_WB: begin
                    regWrite     = 1'b1;
                    memtoReg     = 1'b1;
                    next_state_s = S_FETCH;
                end
                S_MEM_WR: begin
                    wrMem = 1'b1;
                    if (wait_done_s) begin
                        next_state_s = S_FETCH;
                    end else begin
                        next_state_s = S_MEM_WR;
                    end
                end
                S_BRANCH: begin
                    aluSrcA      = SRCA_REGA;
                    aluSrcB      = SRCB_REGB;
                    ALUOp        = ALUOP_W'(ALU_SUB);
                    pcWriteCond  = 1'b1;
                    pcSource     = PCSRC_ALUOUT;
                    next_state_s = S_FETCH;
                end
                S_JUMP: begin
                    pcWrite      = 1'b1;
                    pcSource     = PCSRC_JUMP;
                    next_state_s = S_FETCH;
                end
                S_TRAP: begin
                    next_state_s = S_TRAP;
                end
                default: begin
                    next_state_s = S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_fsm_mc.sv
// Scoreboard bench for control_fsm_mc. Three instances (MEM_WAIT = 0, 1, 2)
// share clock and inputs; stimulus pushes the expected per-cycle control word
// of the selected instance, a negedge monitor pops and compares.
module tb_control_fsm_mc;

    localparam int NDUT = 3;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       alu_out_write;
        logic       mem_rd;
        logic       wr_mem;
        logic       load_ir;
        logic       reg_a_write;
        logic       reg_b_write;
        logic       reg_write;
        logic       reg_dst;
        logic       memto_reg;
        logic       excp;
    } ctl_t;

    typedef struct {
        int    dut;
        ctl_t  v;
        string tag;
    } exp_t;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic       zero   = 1'b0;
    ctl_t       act_a [NDUT];
    exp_t       exp_q [$];
    exp_t       cur;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        logic       pw, pwc, asa, aow, mr, wm, li, raw, rbw, rw, rd, mtr, ex;
        logic [1:0] ps, asb;
        logic [2:0] aop;
        control_fsm_mc #(.MEM_WAIT(g), .ALUOP_W(3), .CNT_W(2)) u_dut (
            .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
            .pcWrite(pw), .pcWriteCond(pwc), .pcSource(ps), .ALUOp(aop),
            .aluSrcA(asa), .aluSrcB(asb), .aluOutWrite(aow), .memRd(mr),
            .wrMem(wm), .Load_ir(li), .regAWrite(raw), .regBWrite(rbw),
            .regWrite(rw), .regDst(rd), .memtoReg(mtr), .excp(ex)
        );
        assign act_a[g] = {pw, pwc, ps, aop, asa, asb, aow, mr, wm, li,
                           raw, rbw, rw, rd, mtr, ex};
    end

    // Expected control word per phase, written straight from the state table.
    function automatic ctl_t ph(input string s, input bit last);
        ctl_t v;
        v = '0;
        case (s)
            "FETCH": begin
                v.mem_rd = 1'b1;
                if (last) begin
                    v.load_ir = 1'b1; v.pc_write = 1'b1;
                    v.alu_src_b = 2'd1; v.alu_op = 3'd1;
                end
            end
            "DECODE": begin
                v.reg_a_write = 1'b1; v.reg_b_write = 1'b1;
                v.alu_src_b = 2'd3; v.alu_op = 3'd1; v.alu_out_write = 1'b1;
            end
            "EXEC_R": begin
                v.alu_src_a = 1'b1; v.alu_op = 3'd7; v.alu_out_write = 1'b1;
            end
            "WB_R":   begin v.reg_write = 1'b1; v.reg_dst = 1'b1; end
            "EXEC_I", "MEM_ADDR": begin
                v.alu_src_a = 1'b1; v.alu_src_b = 2'd2;
                v.alu_op = 3'd1; v.alu_out_write = 1'b1;
            end
            "WB_I":   v.reg_write = 1'b1;
            "MEM_RD": v.mem_rd = 1'b1;
            "MEM_WB": begin v.reg_write = 1'b1; v.memto_reg = 1'b1; end
            "MEM_WR": v.wr_mem = 1'b1;
            "BRANCH": begin
                v.alu_src_a = 1'b1; v.alu_op = 3'd2;
                v.pc_write_cond = 1'b1; v.pc_source = 2'd1;
            end
            "JUMP":   begin v.pc_write = 1'b1; v.pc_source = 2'd2; end
            "TRAP":   v.excp = 1'b1;
            default:  v = '0;
        endcase
        return v;
    endfunction

    task automatic push(input int d, input ctl_t v, input string t);
        exp_t e;
        e.dut = d; e.v = v; e.tag = t;
        exp_q.push_back(e);
    endtask

    // Issue one instruction on instance d; lim truncates the checked/run cycles.
    task automatic issue(input int d, input logic [5:0] op, input logic z,
                         input string nm, input int lim);
        string s[$];
        bit    l[$];
        int    k;
        opcode = op;
        zero   = z;
        for (int i = 0; i <= d; i++) begin s.push_back("FETCH"); l.push_back(i == d); end
        s.push_back("DECODE"); l.push_back(1'b0);
        case (op)
            6'h00: begin s.push_back("EXEC_R"); s.push_back("WB_R"); end
            6'h08: begin s.push_back("EXEC_I"); s.push_back("WB_I"); end
            6'h23: begin
                s.push_back("MEM_ADDR");
                for (int i = 0; i <= d; i++) s.push_back("MEM_RD");
                s.push_back("MEM_WB");
            end
            6'h2B: begin
                s.push_back("MEM_ADDR");
                for (int i = 0; i <= d; i++) s.push_back("MEM_WR");
            end
            6'h04:   s.push_back("BRANCH");
            6'h02:   s.push_back("JUMP");
            default: s.push_back("TRAP");
        endcase
        while (l.size() < s.size()) l.push_back(1'b0);
        k = (s.size() < lim) ? s.size() : lim;
        for (int i = 0; i < k; i++)
            push(d, ph(s[i], l[i]), $sformatf("%s_c%0d_%s", nm, i + 1, s[i]));
        repeat (k) @(posedge clk);
        #1;
    endtask

    // Reset for n cycles; first-cycle excp is still the old register value.
    task automatic do_reset(input int d, input logic exc_first, input int n);
        ctl_t v;
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            v = '0;
            v.excp = (i == 0) ? exc_first : 1'b0;
            push(d, v, $sformatf("reset_c%0d", i + 1));
        end
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: compare one expected word per cycle, away from the clock edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            checks++;
            if (act_a[cur.dut] !== cur.v) begin
                errors++;
                $display("FAIL %s dut%0d got %h expected %h",
                         cur.tag, cur.dut, act_a[cur.dut], cur.v);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        do_reset(0, 1'b0, 2);
        // MEM_WAIT=0: R, ADDI, BEQ taken / not taken, J, back to R.
        issue(0, 6'h00, 1'b0, "r_w0", 100);
        issue(0, 6'h08, 1'b0, "addi_w0", 100);
        issue(0, 6'h04, 1'b1, "beq_z1_w0", 100);
        issue(0, 6'h04, 1'b0, "beq_z0_w0", 100);
        issue(0, 6'h02, 1'b0, "j_w0", 100);
        issue(0, 6'h00, 1'b0, "r2_w0", 100);
        // MEM_WAIT=2: LW, ADDI, J.
        do_reset(2, 1'b0, 1);
        issue(2, 6'h23, 1'b0, "lw_w2", 100);
        issue(2, 6'h08, 1'b0, "addi_w2", 100);
        issue(2, 6'h02, 1'b0, "j_w2", 100);
        // MEM_WAIT=1: SW, BEQ, LW.
        do_reset(1, 1'b0, 1);
        issue(1, 6'h2B, 1'b0, "sw_w1", 100);
        issue(1, 6'h04, 1'b1, "beq_w1", 100);
        issue(1, 6'h23, 1'b0, "lw_w1", 100);
        // Reset in the second MEM_RD cycle, then a full LW from clean FETCH.
        do_reset(2, 1'b0, 1);
        issue(2, 6'h23, 1'b0, "lw_cut_w2", 6);
        do_reset(2, 1'b0, 1);
        issue(2, 6'h23, 1'b0, "lw_after_w2", 100);
        // Illegal opcode trap, held 20 cycles, cleared by reset.
        do_reset(0, 1'b0, 1);
        issue(0, 6'h3F, 1'b0, "trap_w0", 100);
        for (int i = 0; i < 20; i++) push(0, ph("TRAP", 1'b0), $sformatf("trap_hold%0d", i));
        repeat (20) @(posedge clk);
        #1;
        do_reset(0, 1'b1, 1);
        issue(0, 6'h00, 1'b0, "r_after_trap", 100);

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
